// File: rtl/log2_scheduler.sv
// Shares one pipelined log2 unit among NUM_REQ requesters: round-robin issue,
// a tag pipe that tracks the unit in lockstep, and a drain/flush controller.
module log2_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          unit_en,
  output logic                          unit_vld_in,
  output logic [DATA_WIDTH-1:0]         unit_oprand,
  input  logic                          unit_vld_out,
  input  logic [DATA_WIDTH-1:0]         unit_result,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FLUSHED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [LAT-1:0][TW-1:0]  tag_id_q, tag_id_d;
  logic [CW-1:0]           count_q, count_d;

  logic [TW-1:0]           tag_out;
  logic [TW-1:0]           gnt;
  logic [TW-1:0]           idx;
  logic                    found;
  logic                    stall;
  logic                    rsp_hs;
  logic                    can_issue;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   op_sel;

  assign tag_out = tag_id_q[LAT-1];

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a stalled response holds the whole unit.
  always_comb begin
    stall     = unit_vld_out & ~rst & ~rsp_ready[tag_out];
    rsp_hs    = unit_vld_out & ~rst & rsp_ready[tag_out];
    unit_en   = ~stall;
    rsp_valid = '0;
    if (unit_vld_out && !rst) rsp_valid[tag_out] = 1'b1;
    rsp_data  = unit_result;
  end

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = TW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    op_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt == TW'(k)) op_sel = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A full counter can only coincide with a retiring head, so the guard never
  // costs throughput; it just keeps the counter bounded by construction.
  always_comb begin
    can_issue   = ~rst & (state_q == ST_RUN) & unit_en &
                  ((count_q != CW'(LAT)) | rsp_hs);
    accept      = can_issue & found;
    req_ready   = '0;
    if (accept) req_ready[gnt] = 1'b1;
    unit_vld_in = accept;
    unit_oprand = accept ? op_sel : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + TW'(1);

    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (unit_en) begin
      tag_vld_d[0] = accept;
      tag_id_d[0]  = gnt;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_d[s] = tag_vld_q[s-1];
        tag_id_d[s]  = tag_id_q[s-1];
      end
    end

    count_d = count_q;
    if (accept && !rsp_hs)      count_d = count_q + CW'(1);
    else if (!accept && rsp_hs) count_d = count_q - CW'(1);

    state_d = state_q;
    case (state_q)
      ST_RUN:     if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!flush_req)          state_d = ST_RUN;
        else if (count_q == '0)  state_d = ST_FLUSHED;
      end
      ST_FLUSHED: if (!flush_req) state_d = ST_RUN;
      default:                    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      count_q   <= count_d;
    end
  end

  assign busy       = (count_q != '0);
  assign flush_done = (state_q == ST_FLUSHED);
  assign dbg_state  = state_q;

  a_tag_align: assert property (@(posedge clk) disable iff (rst)
    tag_vld_q[LAT-1] == unit_vld_out);
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(LAT));

endmodule

// File: tb/tb_log2_scheduler.sv
// Bench for log2_scheduler: behavioural log2 unit, in-order scoreboard with a
// round-robin/flush reference, vector table and directed corner sequences.
module tb_log2_scheduler;
  localparam int NUM_REQ = 4;
  localparam int W       = 32;
  localparam int LAT     = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*W-1:0]   req_data;
  logic [W-1:0]           rsp_data, unit_oprand, unit_result;
  logic                   unit_en, unit_vld_in, unit_vld_out;
  logic                   flush_req, flush_done, busy;
  logic [1:0]             dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log2_scheduler #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .unit_en(unit_en), .unit_vld_in(unit_vld_in), .unit_oprand(unit_oprand),
    .unit_vld_out(unit_vld_out), .unit_result(unit_result),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact log2 for powers of two and the IEEE specials; other operands map to
  // an arbitrary but deterministic pattern so routing errors stay visible.
  function automatic logic [31:0] log2_ref(input logic [31:0] x);
    int e, a, p;
    if (x == 32'h0000_0000) return 32'hFF80_0000;
    if (x == 32'h7F80_0000) return 32'h7F80_0000;
    if (!x[31] && x[22:0] == 23'd0 && x[30:23] != 8'h00 && x[30:23] != 8'hFF) begin
      e = int'(x[30:23]) - 127;
      if (e == 0) return 32'h0000_0000;
      a = (e < 0) ? -e : e;
      p = 0;
      for (int b = 0; b < 8; b++) if (a[b]) p = b;
      return {e < 0, 8'(127 + p), 23'((a << (23 - p)) & 32'h007F_FFFF)};
    end
    return x ^ 32'h5A5A_0F0F;
  endfunction

  logic           u_vld [LAT];
  logic [W-1:0]   u_dat [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) u_vld[i] <= 1'b0;
    end else if (unit_en) begin
      u_vld[0] <= unit_vld_in;
      u_dat[0] <= log2_ref(unit_oprand);
      for (int i = 1; i < LAT; i++) begin
        u_vld[i] <= u_vld[i-1];
        u_dat[i] <= u_dat[i-1];
      end
    end
  end

  assign unit_vld_out = u_vld[LAT-1];
  assign unit_result  = u_dat[LAT-1];

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           en_q[$];
  int           acc_log[$];
  bit           front_seen;
  int           en_cnt;
  int           ref_state;   // 0 run, 1 drain, 2 flushed
  int           ref_ptr;

  always @(posedge clk) begin : monitor
    logic [NUM_REQ-1:0] exp_rv;
    bit                 stall_r, allowed;
    int                 g, cnt_pre;
    if (rst) begin
      exp_q.delete(); tag_q.delete(); en_q.delete(); acc_log.delete();
      front_seen = 0; en_cnt = 0; ref_state = 0; ref_ptr = 0;
    end else begin
      cnt_pre = tag_q.size();
      exp_rv  = '0;
      stall_r = 0;
      if (unit_vld_out) begin
        if (cnt_pre == 0) chk("orphan_result", 1, 0);
        else begin
          exp_rv[tag_q[0]] = 1'b1;
          stall_r = !rsp_ready[tag_q[0]];
          if (!front_seen) begin
            chk("latency", en_cnt - en_q[0], LAT);
            front_seen = 1;
          end
        end
      end
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_data_pass", rsp_data, unit_result);
      chk("unit_en", unit_en, !stall_r);
      chk("busy", busy, cnt_pre != 0);
      chk("flush_done", flush_done, ref_state == 2);

      allowed = (ref_state == 0) && !stall_r;
      g = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && req_valid[(ref_ptr + k) % NUM_REQ]) g = (ref_ptr + k) % NUM_REQ;
      if (allowed && g >= 0) begin
        chk("req_ready", req_ready, 1 << g);
        chk("unit_vld_in", unit_vld_in, 1);
        chk("unit_oprand", unit_oprand, req_data[g*W +: W]);
      end else begin
        chk("req_ready_idle", req_ready, 0);
        chk("unit_vld_in_idle", unit_vld_in, 0);
        chk("unit_oprand_idle", unit_oprand, 0);
      end

      if (unit_vld_out && cnt_pre != 0 && rsp_ready[tag_q[0]]) begin
        chk("rsp_value", rsp_data, exp_q[0]);
        void'(exp_q.pop_front()); void'(tag_q.pop_front()); void'(en_q.pop_front());
        front_seen = 0;
      end
      if (allowed && g >= 0) begin
        exp_q.push_back(log2_ref(req_data[g*W +: W]));
        tag_q.push_back(g);
        en_q.push_back(en_cnt);
        acc_log.push_back(g);
        ref_ptr = (g + 1) % NUM_REQ;
      end
      if (!stall_r) en_cnt++;

      case (ref_state)
        0: if (flush_req) ref_state = 1;
        1: if (!flush_req) ref_state = 0; else if (cnt_pre == 0) ref_state = 2;
        default: if (!flush_req) ref_state = 0;
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; flush_req = 1'b0; rsp_ready = '1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = '1; req_valid = '0; n = 0;
    while (tag_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", tag_q.size(), 0);
    #1 chk("drain_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_unit_vld_in"}, unit_vld_in, 0);
    chk({tag, "_unit_en"}, unit_en, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
  } vec_t;

  initial begin : main
    vec_t vecs[8];
    int   ord[5];
    int   lat_k, r, na, n;
    bit   hit;
    logic [W-1:0] held;

    vecs[0] = '{32'h4100_0000, 32'h4040_0000};  // 8.0 -> 3.0
    vecs[1] = '{32'h3F80_0000, 32'h0000_0000};  // 1.0 -> 0.0
    vecs[2] = '{32'h0000_0000, 32'hFF80_0000};  // 0 -> -inf
    vecs[3] = '{32'h7F80_0000, 32'h7F80_0000};  // +inf -> +inf
    vecs[4] = '{32'h4080_0000, 32'h4000_0000};  // 4.0 -> 2.0
    vecs[5] = '{32'h3F00_0000, 32'hBF80_0000};  // 0.5 -> -1.0
    vecs[6] = '{32'h4480_0000, 32'h4120_0000};  // 1024.0 -> 10.0
    vecs[7] = '{32'h4000_0000, 32'h3F80_0000};  // 2.0 -> 1.0
    ord = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '1; req_data = '0; rsp_ready = '1; flush_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0; req_valid = '0;

    // single transactions from the table, rotating the requester
    for (int i = 0; i < 8; i++) begin
      r = i % NUM_REQ;
      @(negedge clk);
      req_data[r*W +: W] = vecs[i].op;
      req_valid = NUM_REQ'(1) << r;
      hit = 0;
      for (lat_k = 1; lat_k <= 20; lat_k++) begin
        @(negedge clk);
        if (lat_k == 1) req_valid = '0;
        #1;
        if (rsp_valid[r]) begin hit = 1; break; end
      end
      chk("tbl_seen", hit, 1);
      chk("tbl_latency", lat_k, LAT);
      chk("tbl_result", rsp_data, vecs[i].res);
    end
    drain();

    // contention: everyone requests continuously from a fresh pointer
    do_reset();
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = '1;
    repeat (5) @(negedge clk);
    req_valid = '0;
    chk("cont_count", acc_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("cont_order", (acc_log.size() > i) ? acc_log[i] : -1, ord[i]);
    drain();

    // backpressure on requester 1's head result
    do_reset();
    rsp_ready = 4'b1101;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0101;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      #1 hit = rsp_valid[1];
    end
    chk("bp_head_seen", hit, 1);
    held = rsp_data;
    na = acc_log.size();
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_unit_en", unit_en, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_stable", rsp_data, held);
    end
    chk("bp_no_accept", acc_log.size(), na);
    drain();

    // flush with three results in flight
    do_reset();
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0111;
    repeat (3) @(negedge clk);
    req_valid = '0;
    flush_req = 1'b1;
    na = acc_log.size();
    chk("fl_inflight", na, 3);
    @(negedge clk);
    req_valid = '1;
    hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      #1 hit = flush_done;
    end
    chk("fl_done", hit, 1);
    chk("fl_no_accept", acc_log.size(), na);
    chk("fl_busy", busy, 0);
    flush_req = 1'b0;
    hit = 0;
    for (int k = 0; k < 5 && !hit; k++) begin
      @(negedge clk);
      hit = (acc_log.size() > na);
    end
    chk("fl_resume", hit, 1);
    drain();

    // reset with four results in flight
    do_reset();
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = '1;
    repeat (4) @(negedge clk);
    chk("rs_inflight", tag_q.size(), 4);
    rst = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    n = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      #1 if (rsp_valid != '0) n++;
    end
    chk("rs_no_stale", n, 0);
    req_valid = '1;
    @(negedge clk);
    req_valid = '0;
    chk("rs_ptr_zero", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
    drain();

    // randomized traffic with backpressure and flush toggling
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int b = 0; b < NUM_REQ; b++) begin
        rsp_ready[b] = ($urandom_range(0, 3) != 0);
        req_data[b*W +: W] = $urandom_range(0, 1) ? vecs[$urandom_range(0, 7)].op : $urandom;
      end
      if ($urandom_range(0, 99) < 3) flush_req = ~flush_req;
    end
    flush_req = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/log2_scheduler.md
LOG2_SCHEDULER -- requirements
Module: log2_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one log2 pipeline.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: FP32 operand/result width.
REQ-003 SHALL have parameter LAT, default 6: log2 unit latency in enabled clock edges, vld_in to vld_out.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester operand valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ: per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: operands; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port rsp_valid, output, NUM_REQ: per-requester result valid, one-hot or zero.
REQ-010 SHALL have port rsp_ready, input, NUM_REQ: per-requester result accept.
REQ-011 SHALL have port rsp_data, output, DATA_WIDTH: result, shared by all requesters.
REQ-012 SHALL have port unit_en, output, 1: pipeline enable to log2 unit.
REQ-013 SHALL have port unit_vld_in / unit_oprand, output, 1 / DATA_WIDTH: issue to log2 unit.
REQ-014 SHALL have port unit_vld_out / unit_result, input, 1 / DATA_WIDTH: log2 unit output.
REQ-015 SHALL have port flush_req, input, 1: level; stop issuing, drain pipeline.
REQ-016 SHALL have port flush_done, output, 1: high while drained in FLUSH state.
REQ-017 SHALL have port busy, output, 1: in-flight count nonzero.

Function
REQ-018 SHALL implement states RUN, DRAIN, FLUSHED; reset state RUN.
REQ-019 SHALL transition RUN->DRAIN when flush_req=1; DRAIN->FLUSHED when in-flight count=0; FLUSHED->RUN when flush_req=0; DRAIN->RUN when flush_req drops before empty.
REQ-020 SHALL drive stall = unit_vld_out & ~rsp_ready[tag_out]; unit_en = ~stall (combinational).
REQ-021 SHALL grant only in RUN with unit_en=1; grant = round-robin among req_valid, searching from pointer rr_ptr upward mod NUM_REQ.
REQ-022 SHALL assert req_ready[g] only for granted g; acceptance = req_valid[g] & req_ready[g].
REQ-023 SHALL drive unit_vld_in = acceptance, unit_oprand = req_data of g (zero when none).
REQ-024 SHALL update rr_ptr to (g+1) mod NUM_REQ on acceptance only; hold otherwise.
REQ-025 SHALL keep a LAT-deep tag shift register (clog2(NUM_REQ) bits + valid) advancing only when unit_en=1, lockstep with unit; tag_out = last stage.
REQ-026 SHALL drive rsp_valid[tag_out] = unit_vld_out, other bits 0; rsp_data = unit_result unmodified.
REQ-027 SHALL hold rsp_valid/rsp_data stable while stalled until rsp_ready[tag_out]=1.
REQ-028 SHALL keep in-flight counter, width clog2(LAT+1): +1 on acceptance, -1 on response handshake, unchanged on both same cycle; never exceed LAT.
REQ-029 SHALL assert busy = (count != 0); flush_done = (state==FLUSHED).
REQ-030 SHALL add no forward-path register: rsp_valid rises exactly LAT enabled edges after acceptance edge.
REQ-031 SHALL allow back-to-back acceptance every enabled cycle (throughput 1/cycle).
REQ-032 SHALL treat stall and new request same cycle: no grant, req_ready=0.
REQ-033 SHALL flag tag-valid/unit_vld_out mismatch only via assertion, not in logic.

Reset
REQ-034 SHALL on rst=1 asynchronously clear state to RUN, rr_ptr to 0, tag pipe to invalid, count to 0.
REQ-035 SHALL during reset drive req_ready=0, rsp_valid=0, unit_vld_in=0, unit_en=1, busy=0, flush_done=0.
REQ-036 SHALL discard in-flight results on reset mid-operation; unit is reset concurrently by system.

Verification
REQ-037 Single: req 0 sends 0x41000000 (8.0) -> rsp_valid[0] after 6 edges, rsp_data 0x40400000 (3.0); 0x3F800000 -> 0x00000000.
REQ-038 Contention: all 4 req_valid held -> acceptances 0,1,2,3,0 on consecutive cycles, responses in same order.
REQ-039 Backpressure: rsp_ready[1]=0 for 5 cycles on head result -> unit_en=0, rsp_data stable, no acceptance; releases in order, no loss.
REQ-040 Flush: flush_req during 3 in-flight -> no acceptance, flush_done after last response, busy=0; drop flush_req -> RUN, issue resumes.
REQ-041 Reset mid-stream: rst pulse with 4 in-flight -> all outputs reset values, rr_ptr=0, no stale rsp_valid afterward.
REQ-042 Specials: 0x00000000 -> 0xFF800000 (-inf); 0x7F800000 -> 0x7F800000.
